// File: rtl/safe_zone_checker.sv
`default_nettype none
// =============================================================================
// Module   : safe_zone_checker
// Brief    : Checks the player box's four corners against the safe-zone map once per frame tick.
//            Optional grace counter enabled by defining SAFE_ZONE_GRACE_EN.
// Revision : 1.0 - initial release
// =============================================================================
module safe_zone_checker #(
  parameter int SCREEN_WIDTH  = 400,
  parameter int SCREEN_HEIGHT = 600,
  parameter int PLAYER_SIZE   = 16,
  parameter int GRACE_CHECKS  = 3,
  localparam int XW = $clog2(SCREEN_WIDTH),
  localparam int YW = $clog2(SCREEN_HEIGHT)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          i_frame_tick,
  input  logic          i_level_restart,
  input  logic [XW-1:0] i_player_x,
  input  logic [YW-1:0] i_player_y,
  input  logic          i_zone_rdy,
  output logic [XW-1:0] o_qx,
  output logic [YW-1:0] o_qy,
  input  logic          i_is_safe,
  output logic          o_busy,
  output logic          o_check_valid,
  output logic          o_on_safe,
  output logic          o_hit,
  output logic [7:0]    o_unsafe_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_CHK0 = 3'd2;
  localparam logic [2:0] S_CHK1 = 3'd3;
  localparam logic [2:0] S_CHK2 = 3'd4;
  localparam logic [2:0] S_CHK3 = 3'd5;

  localparam logic [XW:0] c_XMAX = (XW+1)'(SCREEN_WIDTH - 1);
  localparam logic [YW:0] c_YMAX = (YW+1)'(SCREEN_HEIGHT - 1);
  localparam logic [XW:0] c_XOFF = (XW+1)'(PLAYER_SIZE - 1);
  localparam logic [YW:0] c_YOFF = (YW+1)'(PLAYER_SIZE - 1);

  logic [2:0]    state_q, state_d;
  logic          acc_q, acc_d;
  logic [XW-1:0] x0_q, x1_q, qx_q, qx_d;
  logic [YW-1:0] y0_q, y1_q, qy_q, qy_d;
  logic          valid_q, on_safe_q, hit_q, hit_d;

  // Corners from the live inputs; one extra bit keeps x0+size-1 from wrapping.
  logic [XW:0]   w_x0_ext, w_x1_sum;
  logic [YW:0]   w_y0_ext, w_y1_sum;
  logic [XW-1:0] w_in_x0, w_in_x1, w_x0_src;
  logic [YW-1:0] w_in_y0, w_in_y1, w_y0_src;

  assign w_x0_ext = ({1'b0, i_player_x} > c_XMAX) ? c_XMAX : {1'b0, i_player_x};
  assign w_y0_ext = ({1'b0, i_player_y} > c_YMAX) ? c_YMAX : {1'b0, i_player_y};
  assign w_x1_sum = w_x0_ext + c_XOFF;
  assign w_y1_sum = w_y0_ext + c_YOFF;
  assign w_in_x0  = w_x0_ext[XW-1:0];
  assign w_in_y0  = w_y0_ext[YW-1:0];
  assign w_in_x1  = (w_x1_sum > c_XMAX) ? c_XMAX[XW-1:0] : w_x1_sum[XW-1:0];
  assign w_in_y1  = (w_y1_sum > c_YMAX) ? c_YMAX[YW-1:0] : w_y1_sum[YW-1:0];

  assign w_x0_src = (state_q == S_IDLE) ? w_in_x0 : x0_q;
  assign w_y0_src = (state_q == S_IDLE) ? w_in_y0 : y0_q;

  logic w_done, w_result, w_start;
  assign w_start  = (state_q == S_IDLE) && i_frame_tick;
  assign w_done   = (state_q == S_CHK3) && i_zone_rdy;
  assign w_result = acc_q & i_is_safe;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: if (i_frame_tick) begin
        state_d = i_zone_rdy ? S_CHK0 : S_WAIT;
        acc_d   = 1'b1;
      end
      S_WAIT: if (i_zone_rdy) begin
        state_d = S_CHK0;
        acc_d   = 1'b1;
      end
      S_CHK0, S_CHK1, S_CHK2, S_CHK3: begin
        if (!i_zone_rdy) begin
          state_d = S_WAIT;
          acc_d   = 1'b1;
        end else begin
          acc_d = w_result;
          case (state_q)
            S_CHK0:  state_d = S_CHK1;
            S_CHK1:  state_d = S_CHK2;
            S_CHK2:  state_d = S_CHK3;
            default: state_d = S_IDLE;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The query registers present the corner belonging to the state being entered.
  always_comb begin
    qx_d = qx_q;
    qy_d = qy_q;
    case (state_d)
      S_WAIT, S_CHK0: begin qx_d = w_x0_src; qy_d = w_y0_src; end
      S_CHK1:         begin qx_d = x1_q;     qy_d = y0_q;     end
      S_CHK2:         begin qx_d = x0_q;     qy_d = y1_q;     end
      S_CHK3:         begin qx_d = x1_q;     qy_d = y1_q;     end
      default:        ;
    endcase
  end

`ifdef SAFE_ZONE_GRACE_EN
  logic [7:0] cnt_q, cnt_d, w_cnt_inc;
  assign w_cnt_inc = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

  always_comb begin
    cnt_d = cnt_q;
    hit_d = 1'b0;
    if (w_done) begin
      if (w_result) begin
        cnt_d = 8'd0;
      end else if (w_cnt_inc == 8'(GRACE_CHECKS)) begin
        cnt_d = 8'd0;
        hit_d = 1'b1;
      end else begin
        cnt_d = w_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n || i_level_restart) cnt_q <= 8'd0;
    else                            cnt_q <= cnt_d;
  end

  assign o_unsafe_cnt = cnt_q;
`else
  logic w_unused_grace;
  assign w_unused_grace = (GRACE_CHECKS == 0);
  assign hit_d          = w_done & ~w_result;
  assign o_unsafe_cnt   = 8'd0;
`endif

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= 1'b1;
      qx_q      <= '0;
      qy_q      <= '0;
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      valid_q   <= 1'b0;
      on_safe_q <= 1'b1;
      hit_q     <= 1'b0;
    end else if (i_level_restart) begin
      state_q   <= S_IDLE;
      acc_q     <= 1'b1;
      valid_q   <= 1'b0;
      on_safe_q <= 1'b1;
      hit_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
      valid_q <= w_done;
      hit_q   <= hit_d;
      if (w_done) on_safe_q <= w_result;
      if (w_start) begin
        x0_q <= w_in_x0;
        x1_q <= w_in_x1;
        y0_q <= w_in_y0;
        y1_q <= w_in_y1;
      end
    end
  end

  assign o_qx          = qx_q;
  assign o_qy          = qy_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_check_valid = valid_q;
  assign o_on_safe     = on_safe_q;
  assign o_hit         = hit_q;

endmodule
`default_nettype wire

// File: tb/tb_safe_zone_checker.sv
`default_nettype none
// =============================================================================
// Module   : tb_safe_zone_checker
// Brief    : Directed bench for safe_zone_checker with a block-grid map model (20-pixel blocks).
// Revision : 1.0 - initial release
// =============================================================================
module tb_safe_zone_checker;

`ifdef SAFE_ZONE_GRACE_EN
  localparam bit GRACE = 1'b1;
`else
  localparam bit GRACE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       level_restart = 1'b0;
  logic       zone_rdy = 1'b1;
  logic       is_safe;
  logic [8:0] player_x = 9'd0;
  logic [9:0] player_y = 10'd0;
  logic [8:0] qx;
  logic [9:0] qy;
  logic       busy, cv, on_safe, hit;
  logic [7:0] unsafe_cnt;
  logic       map_mode = 1'b0;
  int         n_assert = 0;
  int         n_fail = 0;
  int         cv_seen;
  int         hit_seen;

  safe_zone_checker dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .i_frame_tick   (frame_tick),
    .i_level_restart(level_restart),
    .i_player_x     (player_x),
    .i_player_y     (player_y),
    .i_zone_rdy     (zone_rdy),
    .o_qx           (qx),
    .o_qy           (qy),
    .i_is_safe      (is_safe),
    .o_busy         (busy),
    .o_check_valid  (cv),
    .o_on_safe      (on_safe),
    .o_hit          (hit),
    .o_unsafe_cnt   (unsafe_cnt)
  );

  always #5 clk = ~clk;

  // Map model: mode 1 marks block (5,10) unsafe, mode 0 is all-safe.
  always_comb is_safe = !(map_mode && ((int'(qx) / 20) == 5) && ((int'(qy) / 20) == 10));

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input int ex, input int ey);
    chk({tag, "_qx"}, 32'(qx), 32'(ex));
    chk({tag, "_qy"}, 32'(qy), 32'(ey));
  endtask

  // Tick, then advance to cycle n+5 where the result is visible.
  task automatic run_check(input int x, input int y);
    player_x   = 9'(x);
    player_y   = 10'(y);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (4) step();
  endtask

  task automatic chk_res(input string tag, input bit e_safe, input bit e_hit, input int e_cnt);
    chk({tag, "_valid"}, 32'(cv), 32'd1);
    chk({tag, "_on_safe"}, 32'(on_safe), 32'(e_safe));
    chk({tag, "_hit"}, 32'(hit), 32'(e_hit));
    chk({tag, "_cnt"}, 32'(unsafe_cnt), 32'(e_cnt));
  endtask

  task automatic restart_pulse();
    level_restart = 1'b1;
    step();
    level_restart = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (3) step();
    chk("rst_qx", 32'(qx), 32'd0);
    chk("rst_qy", 32'(qy), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(cv), 32'd0);
    chk("rst_on_safe", 32'(on_safe), 32'd1);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_cnt", 32'(unsafe_cnt), 32'd0);
    arst_n = 1'b1;
    step();

    // All-safe map, corner sequence and n+5 latency
    player_x = 9'd100; player_y = 10'd200; frame_tick = 1'b1;
    step(); frame_tick = 1'b0;
    chk_q("t1_c0", 100, 200);
    chk("t1_busy", 32'(busy), 32'd1);
    step(); chk_q("t1_c1", 115, 200);
    step(); chk_q("t1_c2", 100, 215);
    step(); chk_q("t1_c3", 115, 215);
    chk("t1_valid_early", 32'(cv), 32'd0);
    step();
    chk_res("t1", 1'b1, 1'b0, 0);
    chk("t1_idle", 32'(busy), 32'd0);
    step();
    chk("t1_valid_pulse", 32'(cv), 32'd0);

    // Unsafe block under the player
    map_mode = 1'b1;
    run_check(100, 200);
    chk_res("t2", 1'b0, !GRACE, GRACE ? 1 : 0);
    step();
    chk("t2_hit_pulse", 32'(hit), 32'd0);

    // Grace sequences
    restart_pulse();
    chk("t3_rst_on_safe", 32'(on_safe), 32'd1);
    chk("t3_rst_cnt", 32'(unsafe_cnt), 32'd0);
    run_check(100, 200); chk_res("t3_u1", 1'b0, !GRACE, GRACE ? 1 : 0);
    run_check(100, 200); chk_res("t3_u2", 1'b0, !GRACE, GRACE ? 2 : 0);
    run_check(100, 200); chk_res("t3_u3", 1'b0, 1'b1, 0);
    run_check(100, 200); chk_res("t3_a", 1'b0, !GRACE, GRACE ? 1 : 0);
    run_check(300, 300); chk_res("t3_b", 1'b1, 1'b0, 0);
    run_check(100, 200); chk_res("t3_c", 1'b0, !GRACE, GRACE ? 1 : 0);

    // Edge clamping
    map_mode = 1'b0;
    player_x = 9'd390; player_y = 10'd590; frame_tick = 1'b1;
    step(); frame_tick = 1'b0;
    chk_q("t4_c0", 390, 590);
    step(); chk_q("t4_c1", 399, 590);
    step(); chk_q("t4_c2", 390, 599);
    step(); chk_q("t4_c3", 399, 599);
    step(); chk("t4_valid", 32'(cv), 32'd1);
    chk("t4_on_safe", 32'(on_safe), 32'd1);
    player_x = 9'd450; player_y = 10'd700; frame_tick = 1'b1;
    step(); frame_tick = 1'b0;
    chk_q("t4_clamp0", 399, 599);
    repeat (4) step();

    // Ready drop during CHK2, tick while busy ignored
    player_x = 9'd100; player_y = 10'd200; frame_tick = 1'b1;
    step(); frame_tick = 1'b0;
    step(); step();
    chk_q("t5_c2", 100, 215);
    zone_rdy = 1'b0; frame_tick = 1'b1; player_x = 9'd200;
    cv_seen = 0;
    step(); frame_tick = 1'b0;
    chk("t5_wait_busy", 32'(busy), 32'd1);
    chk_q("t5_wait", 100, 200);
    cv_seen += int'(cv);
    step(); cv_seen += int'(cv);
    step(); cv_seen += int'(cv);
    step(); zone_rdy = 1'b1; cv_seen += int'(cv);
    step(); cv_seen += int'(cv);
    chk_q("t5_re_c0", 100, 200);
    step(); cv_seen += int'(cv);
    chk_q("t5_re_c1", 115, 200);
    repeat (6) begin step(); cv_seen += int'(cv); end
    chk("t5_valid_count", 32'(cv_seen), 32'd1);
    chk("t5_idle", 32'(busy), 32'd0);

    // Restart mid-check with two unsafe checks banked
    player_x = 9'd100;
    map_mode = 1'b1;
    restart_pulse();
    run_check(100, 200);
    run_check(100, 200);
    chk("t6_pre_cnt", 32'(unsafe_cnt), GRACE ? 32'd2 : 32'd0);
    frame_tick = 1'b1;
    step(); frame_tick = 1'b0;
    step();
    chk_q("t6_c1", 115, 200);
    level_restart = 1'b1;
    step(); level_restart = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_cnt", 32'(unsafe_cnt), 32'd0);
    chk("t6_on_safe", 32'(on_safe), 32'd1);
    cv_seen = int'(cv); hit_seen = int'(hit);
    repeat (5) begin step(); cv_seen += int'(cv); hit_seen += int'(hit); end
    chk("t6_no_valid", 32'(cv_seen), 32'd0);
    chk("t6_no_hit", 32'(hit_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
